imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream writer that fills the processor's 64-word instruction memory before execution starts. Accepts bytes over a valid/ready handshake, packs them MSB-first into 32-bit instruction words, and issues one-cycle word writes with a byte address. Holds the core in reset until the load completes. Sits between a host or debug byte source and the instruction memory's write port; the memory read path (`a` → `rd`) is unchanged.

## Interface
- `DEPTH`, 64: number of instruction words; matches the 64-entry instruction RAM.
- `AW`, 6: word-index width, equal to clog2(`DEPTH`).

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `start` in 1: one-cycle pulse that begins a load at word 0.
- `in_valid` in 1: the source has a byte on `in_byte`.
- `in_ready` out 1: the loader can accept a byte this cycle.
- `in_byte` in 8: data byte, most-significant byte of each word first.
- `in_last` in 1: qualifies the final byte of the stream; sampled with the byte.
- `we` out 1: memory write strobe, one cycle per word.
- `a` out 32: memory byte address, equal to `{word_index, 2'b00}` zero-extended.
- `wd` out 32: word being written.
- `busy` out 1: high in LOAD and WRITE.
- `done` out 1: high in DONE.
- `core_hold` out 1: holds the processor in reset; low only in DONE with no error.
- `word_count` out AW+1: number of words written since the last `start`.
- `csum_err` out 1: checksum mismatch flag; see Configuration.

## Operation
- A byte is accepted only when `in_valid && in_ready` in the same cycle.
- States:
  - IDLE: `in_ready`=0. `start` → LOAD, with the word index, byte counter, `word_count` and checksum cleared.
  - LOAD: `in_ready`=1. Each accepted byte shifts into the word assembly register (`word <= {word[23:0], byte}`) and increments the 2-bit byte counter.
    - Go to WRITE when the 4th byte is accepted.
    - Go to WRITE early when `in_last` accompanies an accepted byte. The missing low bytes are zero-padded: after k bytes, the word is shifted left by 8·(4−k).
  - WRITE: `in_ready`=0 and `we`=1 for exactly one cycle, with `a`/`wd` valid in that cycle. Then the word index and `word_count` increment.
    - Next state is DONE if the last byte carried `in_last` or `word_count` reaches `DEPTH`; otherwise LOAD.
  - DONE: `in_ready`=0 and all further bytes are stalled. `start` → LOAD (reload from word 0). `core_hold`=`csum_err`.
- `start` outside IDLE and DONE is ignored.
- `in_last` on a byte accepted while the byte counter is 0 writes a single-byte-padded word (byte in bits [31:24]).
- Overflow: once `DEPTH` words are written the loader enters DONE even without `in_last`; surplus bytes are never accepted.
- `we`, `a` and `wd` are 0 in every state other than WRITE.

## Timing
- Reset values: `in_ready`=0, `we`=0, `a`=0, `wd`=0, `busy`=0, `done`=0, `core_hold`=1, `word_count`=0, `csum_err`=0; state = IDLE.
- `in_ready` goes high the cycle after `start` is sampled.
- Latency: the 4th byte is accepted at edge N; `we`=1 during cycle N+1. Peak throughput is 4 bytes per 5 cycles.
- `word_count` shows its new value from the edge that ends WRITE.
- Reset asserted mid-load aborts immediately. Partially assembled bytes are discarded and the memory contents are left as written. `core_hold` returns to 1.
- `done` and `core_hold` are registered with no combinational path from any input. `in_ready` depends only on state.

## Configuration
- `IMEM_LOADER_CSUM_EN` defined:
  - The word terminated by `in_last` is a checksum and is not written to memory (`we` stays 0 for it).
  - The loader compares the checksum against the 32-bit modulo-2^32 sum of all previously written words.
  - On mismatch `csum_err`=1 in DONE and `core_hold` stays 1.
  - A load ended by reaching `DEPTH` has no checksum word, and `csum_err`=0.
- Macro undefined: no accumulator is built, `csum_err` is tied to 0, and the word carrying `in_last` is written normally.

## Test plan
- Reset, then `start`, then bytes e3 a0 00 05 e3 a0 10 08 (`in_last` on the final byte) → two writes: `a`=0x0 `wd`=0xe3a00005, then `a`=0x4 `wd`=0xe3a01008. Then `done`=1, `core_hold`=0, `word_count`=2.
- Source deasserts `in_valid` randomly for 1–3 cycles between bytes → identical write sequence; no byte lost or duplicated.
- Bytes e3 a0 with `in_last` on 0xa0 → single write `wd`=0xe3a00000 at `a`=0x0.
- Stream of 260 bytes with no `in_last` → exactly 64 writes (last one at `a`=0xFC), then DONE; `in_ready`=0 for the remaining 4 bytes.
- Reset pulsed after 2 bytes of word 3 → all outputs return to reset values within the same cycle. A following `start` reloads from `a`=0.
- With `IMEM_LOADER_CSUM_EN` defined: words 0x00000001, 0x00000002 followed by checksum 0x00000003 → 2 writes, `csum_err`=0, `core_hold`=0. Repeating with checksum 0x00000004 → `csum_err`=1, `core_hold`=1.

Source files
------------

// File: rtl/imem_loader.sv
// ----------------------------------------------------------------------------
// imem_loader
//
// Fills the 64-word instruction memory from a byte stream before the core
// starts executing. Bytes arrive over a valid/ready handshake. They are packed
// MSB-first into 32-bit words, and each finished word is written with a
// one-cycle strobe. The core is held in reset until the load has finished
// cleanly.
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-high reset
//   start      - one-cycle pulse; begins a load at word 0 (IDLE/DONE only)
//   in_valid   - source presents a byte
//   in_ready   - loader accepts a byte this cycle (LOAD state only)
//   in_byte    - data byte, most-significant byte of each word first
//   in_last    - marks the final byte of the stream
//   we         - memory write strobe, one cycle per word
//   a          - memory byte address {word_index, 2'b00}
//   wd         - memory write data
//   busy       - high while loading or writing
//   done       - high once the load has finished
//   core_hold  - processor reset; low only in DONE without a checksum error
//   word_count - words written since the last start
//   csum_err   - checksum mismatch flag
//
// Optional feature (macro IMEM_LOADER_CSUM_EN):
//   The word terminated by in_last is a checksum. It is compared against the
//   modulo-2^32 sum of all written words and is not itself written. Without
//   the macro, csum_err is tied low and the in_last word is written normally.
// ----------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [7:0]    in_byte,
    input  logic          in_last,
    output logic          we,
    output logic [31:0]   a,
    output logic [31:0]   wd,
    output logic          busy,
    output logic          done,
    output logic          core_hold,
    output logic [AW:0]   word_count,
    output logic          csum_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_DONE
    } state_t;

`ifdef IMEM_LOADER_CSUM_EN
    localparam logic CSUM_EN = 1'b1;
`else
    localparam logic CSUM_EN = 1'b0;
`endif

    state_t        state_q, state_d;
    logic [31:0]   word_q, word_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          last_q, last_d;
    logic [AW:0]   wc_q, wc_d;
    logic          in_ready_q, in_ready_d;
    logic          we_q, we_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   wd_q, wd_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          core_hold_q, core_hold_d;
    logic          csum_err_q, csum_err_d;

    // Next-state and next-output logic. All outputs are registered from the
    // next state, so nothing reaches done/core_hold/in_ready combinationally.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        wc_d    = wc_q;
        we_d    = 1'b0;
        a_d     = 32'd0;
        wd_d    = 32'd0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_LOAD;
                    word_d  = 32'd0;
                    cnt_d   = 2'd0;
                    last_d  = 1'b0;
                    wc_d    = '0;
                end
            end

            S_LOAD: begin
                if (in_valid && in_ready_q) begin
                    cnt_d  = cnt_q + 2'd1;
                    word_d = {word_q[23:0], in_byte};
                    if (in_last || (cnt_q == 2'd3)) begin
                        // Left-justify a short word: after k = cnt_q+1 bytes
                        // the missing 4-k low bytes become zero.
                        word_d  = word_d << {2'd3 - cnt_q, 3'b000};
                        last_d  = in_last;
                        state_d = S_WRITE;
                        // A checksum word passes through WRITE without a strobe.
                        if (!(CSUM_EN && in_last)) begin
                            we_d = 1'b1;
                            a_d  = {{(32-AW-2){1'b0}}, wc_q[AW-1:0], 2'b00};
                            wd_d = word_d;
                        end
                    end
                end
            end

            S_WRITE: begin
                if (we_q) begin
                    wc_d = wc_q + 1'b1;
                end
                cnt_d  = 2'd0;
                word_d = 32'd0;
                if (last_q || (wc_d == (AW+1)'(DEPTH))) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_LOAD;
                end
            end

            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_LOAD);
        busy_d      = (state_d == S_LOAD) || (state_d == S_WRITE);
        done_d      = (state_d == S_DONE);
        core_hold_d = !((state_d == S_DONE) && !csum_err_d);
    end

`ifdef IMEM_LOADER_CSUM_EN
    logic [31:0] csum_q, csum_d;

    // Running sum of written words; compared when the checksum word sits in
    // WRITE (the only time WRITE is entered without a strobe).
    always_comb begin
        csum_d     = csum_q;
        csum_err_d = csum_err_q;
        if (((state_q == S_IDLE) || (state_q == S_DONE)) && start) begin
            csum_d     = 32'd0;
            csum_err_d = 1'b0;
        end else if (state_q == S_WRITE) begin
            if (we_q) begin
                csum_d = csum_q + wd_q;
            end else begin
                csum_err_d = (word_q != csum_q);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q     <= 32'd0;
            csum_err_q <= 1'b0;
        end else begin
            csum_q     <= csum_d;
            csum_err_q <= csum_err_d;
        end
    end
`else
    assign csum_err_d = 1'b0;
    assign csum_err_q = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            word_q      <= 32'd0;
            cnt_q       <= 2'd0;
            last_q      <= 1'b0;
            wc_q        <= '0;
            in_ready_q  <= 1'b0;
            we_q        <= 1'b0;
            a_q         <= 32'd0;
            wd_q        <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            core_hold_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            wc_q        <= wc_d;
            in_ready_q  <= in_ready_d;
            we_q        <= we_d;
            a_q         <= a_d;
            wd_q        <= wd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            core_hold_q <= core_hold_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign we         = we_q;
    assign a          = a_q;
    assign wd         = wd_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign core_hold  = core_hold_q;
    assign word_count = wc_q;
    assign csum_err   = csum_err_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_byte;
    logic          in_last;
    logic          we;
    logic [31:0]   a;
    logic [31:0]   wd;
    logic          busy;
    logic          done;
    logic          core_hold;
    logic [AW:0]   word_count;
    logic          csum_err;

    int n_cmp = 0;
    int n_mis = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte), .in_last(in_last),
        .we(we), .a(a), .wd(wd), .busy(busy), .done(done), .core_hold(core_hold),
        .word_count(word_count), .csum_err(csum_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected {a, wd}.
    initial begin
        forever begin
            @(negedge clk);
            if (we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_mis++;
                    $display("FAIL write_unexpected: got a=0x%0h wd=0x%0h expected no write", a, wd);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("write_addr", {32'd0, a}, {32'd0, mon_e[63:32]});
                    check("write_data", {32'd0, wd}, {32'd0, mon_e[31:0]});
                end
            end
        end
    end

    task automatic push_write(input logic [31:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    // Called and returns at a falling edge.
    task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        in_last  = last;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++;
            n_mis++;
            $display("FAIL byte_accept_timeout: got in_ready=%b expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends the top nbytes of w, MSB first; in_last on the final one if last.
    task automatic send_word(input logic [31:0] w, input int nbytes, input logic last, input int maxgap);
        logic [31:0] s;
        s = w;
        for (int i = 0; i < nbytes; i++) begin
            send_byte(s[31:24], last && (i == nbytes - 1),
                      (maxgap > 0) ? int'($urandom_range(1, maxgap)) : 0);
            s = s << 8;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (done !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check(name, {63'd0, done}, 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},   {63'd0, in_ready},   64'd0);
        check({tag, "_we"},         {63'd0, we},         64'd0);
        check({tag, "_a"},          {32'd0, a},          64'd0);
        check({tag, "_wd"},         {32'd0, wd},         64'd0);
        check({tag, "_busy"},       {63'd0, busy},       64'd0);
        check({tag, "_done"},       {63'd0, done},       64'd0);
        check({tag, "_core_hold"},  {63'd0, core_hold},  64'd1);
        check({tag, "_word_count"}, {57'd0, word_count}, 64'd0);
        check({tag, "_csum_err"},   {63'd0, csum_err},   64'd0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'd0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b0;
        @(negedge clk);
        check("idle_in_ready", {63'd0, in_ready}, 64'd0);

        pulse_start();
        check("load_in_ready", {63'd0, in_ready}, 64'd1);
        check("load_busy", {63'd0, busy}, 64'd1);

`ifndef IMEM_LOADER_CSUM_EN
        // Two-word program, back-to-back bytes.
        push_write(32'h0, 32'he3a00005);
        push_write(32'h4, 32'he3a01008);
        send_word(32'he3a00005, 4, 1'b0, 0);
        send_word(32'he3a01008, 4, 1'b1, 0);
        wait_done("t1_done");
        check("t1_core_hold", {63'd0, core_hold}, 64'd0);
        check("t1_word_count", {57'd0, word_count}, 64'd2);
        check("t1_in_ready", {63'd0, in_ready}, 64'd0);
        check("t1_busy", {63'd0, busy}, 64'd0);

        // Same stream with source gaps; reload from DONE.
        pulse_start();
        check("t2_word_count_clr", {57'd0, word_count}, 64'd0);
        push_write(32'h0, 32'he3a00005);
        push_write(32'h4, 32'he3a01008);
        send_word(32'he3a00005, 4, 1'b0, 3);
        send_word(32'he3a01008, 4, 1'b1, 3);
        wait_done("t2_done");
        check("t2_word_count", {57'd0, word_count}, 64'd2);

        // Two bytes then in_last: zero-padded low half.
        pulse_start();
        push_write(32'h0, 32'he3a00000);
        send_word(32'he3a00000, 2, 1'b1, 0);
        wait_done("t3_done");
        check("t3_word_count", {57'd0, word_count}, 64'd1);
        check("t3_csum_err", {63'd0, csum_err}, 64'd0);

        // in_last on the first byte of a word.
        pulse_start();
        push_write(32'h0, 32'h11223344);
        push_write(32'h4, 32'h7f000000);
        send_word(32'h11223344, 4, 1'b0, 0);
        send_word(32'h7f000000, 1, 1'b1, 0);
        wait_done("t4_done");
        check("t4_word_count", {57'd0, word_count}, 64'd2);
        check("t4_core_hold", {63'd0, core_hold}, 64'd0);
`else
        // Matching checksum.
        push_write(32'h0, 32'h00000001);
        push_write(32'h4, 32'h00000002);
        send_word(32'h00000001, 4, 1'b0, 0);
        send_word(32'h00000002, 4, 1'b0, 0);
        send_word(32'h00000003, 4, 1'b1, 0);
        wait_done("c1_done");
        check("c1_csum_err", {63'd0, csum_err}, 64'd0);
        check("c1_core_hold", {63'd0, core_hold}, 64'd0);
        check("c1_word_count", {57'd0, word_count}, 64'd2);

        // Wrong checksum.
        pulse_start();
        push_write(32'h0, 32'h00000001);
        push_write(32'h4, 32'h00000002);
        send_word(32'h00000001, 4, 1'b0, 2);
        send_word(32'h00000002, 4, 1'b0, 2);
        send_word(32'h00000004, 4, 1'b1, 2);
        wait_done("c2_done");
        check("c2_csum_err", {63'd0, csum_err}, 64'd1);
        check("c2_core_hold", {63'd0, core_hold}, 64'd1);
        check("c2_word_count", {57'd0, word_count}, 64'd2);
`endif

        // Reset after two bytes of word 3.
        pulse_start();
        push_write(32'h0, 32'ha0a1a2a3);
        push_write(32'h4, 32'hb0b1b2b3);
        push_write(32'h8, 32'hc0c1c2c3);
        send_word(32'ha0a1a2a3, 4, 1'b0, 0);
        send_word(32'hb0b1b2b3, 4, 1'b0, 0);
        send_word(32'hc0c1c2c3, 4, 1'b0, 0);
        send_word(32'hd0d10000, 2, 1'b0, 0);
        check("r_busy_before", {63'd0, busy}, 64'd1);
        #2 reset = 1'b1;
        #1 check_reset_values("midrst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pulse_start();
        push_write(32'h0, 32'h5a5a0001);
        send_word(32'h5a5a0001, 4, 1'b0, 0);
        @(negedge clk);
        check("r_word_count", {57'd0, word_count}, 64'd1);

        // Overflow: 256 bytes without in_last fill all 64 words.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        pulse_start();
        for (int j = 0; j < DEPTH; j++) begin
            logic [7:0] b0;
            b0 = 8'(4 * j);
            push_write(32'(4 * j), {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3});
            send_word({b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3}, 4, 1'b0, 0);
        end
        wait_done("ov_done");
        check("ov_word_count", {57'd0, word_count}, 64'd64);
        check("ov_core_hold", {63'd0, core_hold}, 64'd0);
        check("ov_csum_err", {63'd0, csum_err}, 64'd0);
        // Surplus bytes are stalled.
        in_valid = 1'b1;
        in_byte  = 8'h00;
        for (int k = 0; k < 4; k++) begin
            check("ov_surplus_in_ready", {63'd0, in_ready}, 64'd0);
            in_byte = in_byte + 8'd1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("ov_word_count_hold", {57'd0, word_count}, 64'd64);

        repeat (3) @(negedge clk);
        check("pending_writes", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
